fabric_bitstream_framer: RTL
============================

// Module: fabric_bitstream_framer
// PURPOSE
// - Sits between the SPI bitstream multiplexer and fabric_config. Consumes 32-bit bitstream words from
//   either SPI source and hunts for a sync word. It then reads a length header and forwards exactly
//   that many payload words to fabric_config.
// - Optionally checks a trailing CRC-32. Reports done/error so the fabric "configured" flag can be gated.
// PARAMETERS
// - SYNC_WORD        32'hFAB0_FAB1  header word that starts a bitstream
// - MAX_LENGTH_WORDS 32'h0000_1762  largest legal payload length in words
// - TIMEOUT_CYCLES   24'd1_000_000  max idle cycles between words once framing has started
// PORTS
// - clk_i        in   1   system clock
// - rst_ni       in   1   asynchronous reset, active low
// - in_data_i    in   32  bitstream word from SPI mux
// - in_valid_i   in   1   in_data_i valid, single-cycle pulse per word
// - out_data_o   out  32  payload word to fabric_config
// - out_valid_o  out  1   out_data_o valid, one cycle per payload word
// - busy_o       out  1   framing in progress (header accepted, not finished)
// - done_o       out  1   one-cycle pulse: bitstream complete and accepted
// - error_o      out  1   sticky: length/timeout/CRC failure
// BEHAVIOUR
// - One clock (clk_i). Reset is asynchronous, active-low on rst_ni.
// - Reset values: out_data_o=0, out_valid_o=0, busy_o=0, done_o=0, error_o=0; state=HUNT; counters=0.
// - States: HUNT -> LEN -> PAYLOAD -> [CRC] -> HUNT.
//   - HUNT: discard words. A valid word == SYNC_WORD -> LEN; busy_o=1, error_o cleared, CRC reg=32'hFFFF_FFFF.
//   - LEN: the next valid word gives length L=in_data_i[15:0]. If L==0 or L>MAX_LENGTH_WORDS: error_o=1, -> HUNT.
//     Otherwise the remaining count is loaded with L, -> PAYLOAD.
//   - PAYLOAD: each valid word is forwarded with exactly 1 cycle latency: out_data_o/out_valid_o registered.
//     The word updates the CRC and decrements the count. After the Lth word -> CRC (feature on) or
//     HUNT with done_o pulse (feature off).
//   - CRC: the next valid word is compared with the CRC register. Equal -> done_o pulse. Different -> error_o=1.
//     Either way -> HUNT with busy_o=0.
// - SYNC_WORD value inside LEN/PAYLOAD/CRC is treated as ordinary data; no re-hunt.
// - Timeout:
//   - In LEN/PAYLOAD/CRC an idle counter runs while in_valid_i=0 and resets on each valid word.
//   - Reaching TIMEOUT_CYCLES -> error_o=1, busy_o=0, -> HUNT. No further out_valid_o pulses.
// - done_o and error_o are mutually exclusive. done_o asserts the cycle after the final accepted word.
// - error_o holds until the next SYNC_WORD is accepted in HUNT, or until reset.
// - busy_o falls in the same cycle done_o rises or error_o is set.
// - Reset mid-operation: asynchronously returns to HUNT. Any partially forwarded bitstream is abandoned.
// - out_valid_o is never asserted outside PAYLOAD-accepted words. Back-to-back valid words are supported.
// - CRC-32: polynomial 0x04C11DB7, non-reflected, MSB (bit 31) first, init 0xFFFFFFFF, no final XOR.
//   Computed over the payload words only, one full word per cycle.
// CONFIGURATION
// - BITSTREAM_CRC_EN defined: the CRC state and CRC register exist. A trailing CRC word is required after the payload.
// - BITSTREAM_CRC_EN undefined: no CRC logic. done_o pulses after the Lth payload word.
//   A word following the payload is seen in HUNT and discarded unless it equals SYNC_WORD.
// TESTING
// - Reset is released. Words 0x1234_5678 then 0xFAB0_FAB1 arrive, then the length word 0x0000_0002
//   and payload 0xAAAA_5555, 0x0F0F_F0F0, then the golden-model CRC.
//   Required response: only the 2 payload words appear on out_*, each 1 cycle later; done_o pulses once; error_o=0.
// - As above, but the CRC word has bit0 flipped.
//   Required response: both payloads are forwarded; error_o=1; no done_o. A following SYNC_WORD clears error_o.
// - SYNC_WORD arrives, then length word 0x0000_0000 and again with 0x0000_1763.
//   Required response: error_o=1 at once; busy_o=0; no out_valid_o.
// - SYNC_WORD arrives, then length 3; one payload word is sent, then in_valid_i is held low for TIMEOUT_CYCLES.
//   Required response: error_o=1 at exactly TIMEOUT_CYCLES; busy_o=0; a late word is not forwarded.
// - SYNC_WORD, length 4, and a payload containing 0xFAB0_FAB1 are sent back-to-back on every cycle.
//   Required response: all 4 words are forwarded on consecutive cycles in order; no restart.
// - rst_ni is asserted after 2 of 4 payload words. Required response: all outputs are 0 asynchronously;
//   after release, a fresh full bitstream completes with done_o.

Source files
------------

// File: rtl/fabric_bitstream_framer_if.sv
// Bitstream framer bus: incoming SPI-mux words and framed payload/status
// towards fabric_config. The master modport is the word source/observer,
// the slave modport is the framer itself.
interface fabric_bitstream_framer_if;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  modport master (
    output in_data_i, in_valid_i,
    input  out_data_o, out_valid_o, busy_o, done_o, error_o
  );

  modport slave (
    input  in_data_i, in_valid_i,
    output out_data_o, out_valid_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/fabric_bitstream_framer.sv
// fabric_bitstream_framer
// Hunts for SYNC_WORD, reads a 16-bit length header and forwards exactly that
// many payload words with one cycle of latency. Idle gaps longer than
// TIMEOUT_CYCLES abort the frame. Optional feature macro BITSTREAM_CRC_EN adds
// a trailing CRC-32 check (poly 0x04C11DB7, MSB first, init all-ones, no xorout).
module fabric_bitstream_framer #(
  parameter logic [31:0] SYNC_WORD        = 32'hFAB0_FAB1,
  parameter logic [31:0] MAX_LENGTH_WORDS = 32'h0000_1762,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1_000_000
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  fabric_bitstream_framer_if.slave   bus
);

`ifdef BITSTREAM_CRC_EN
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CRC} state_e;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  // Full 32-bit word folded into the CRC, MSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    logic [31:0] d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 32; i++) begin
      if (c[31] ^ d[31]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else               c = {c[30:0], 1'b0};
      d = {d[30:0], 1'b0};
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_d;
`else
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] idle_q, idle_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] len_w;

  assign len_w = bus.in_data_i[15:0];

  // State and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_HUNT;
      cnt_q       <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef BITSTREAM_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef BITSTREAM_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Next-state, counters and output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
`ifdef BITSTREAM_CRC_EN
    crc_d       = crc_q;
`endif

    if (state_q == S_HUNT) begin
      idle_d = '0;
      if (bus.in_valid_i && (bus.in_data_i == SYNC_WORD)) begin
        state_d = S_LEN;
        busy_d  = 1'b1;
        error_d = 1'b0;
`ifdef BITSTREAM_CRC_EN
        crc_d   = '1;
`endif
      end
    end else if (!bus.in_valid_i) begin
      // The TIMEOUT_CYCLES-th consecutive idle cycle aborts the frame.
      if (idle_q == TIMEOUT_CYCLES - 24'd1) begin
        idle_d  = '0;
        state_d = S_HUNT;
        busy_d  = 1'b0;
        error_d = 1'b1;
      end else begin
        idle_d = idle_q + 24'd1;
      end
    end else begin
      idle_d = '0;
      case (state_q)
        S_LEN: begin
          if ((len_w == 16'd0) || ({16'd0, len_w} > MAX_LENGTH_WORDS)) begin
            state_d = S_HUNT;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            cnt_d   = len_w;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data_i;
          cnt_d       = cnt_q - 16'd1;
`ifdef BITSTREAM_CRC_EN
          crc_d       = crc32_step(crc_q, bus.in_data_i);
          if (cnt_q == 16'd1) state_d = S_CRC;
`else
          if (cnt_q == 16'd1) begin
            state_d = S_HUNT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end
`ifdef BITSTREAM_CRC_EN
        S_CRC: begin
          state_d = S_HUNT;
          busy_d  = 1'b0;
          if (bus.in_data_i == crc_q) done_d  = 1'b1;
          else                        error_d = 1'b1;
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end
  end

  assign bus.out_data_o  = out_data_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.error_o     = error_q;

endmodule
